integer_muldiv_unit: RTL and testbench

- Multi-cycle integer execution unit for MIPS MULT/MULTU/DIV/DIVU and MFHI/MFLO/MTHI/MTLO, owning the architectural HI/LO registers.
- Sits beside the single-cycle integer execution unit in the execute stage.
- Adds a valid/ready handshake, a parametrised multiplier latency, an iterative radix-2 divider and flush support. The single-cycle unit has none of these.

---
 rtl/integer_muldiv_unit.sv | 187 ++++++++++++++++++
 tb/tb_integer_muldiv_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/integer_muldiv_unit.sv
// integer_muldiv_unit: multi-cycle MIPS MULT/DIV/MF/MT unit owning HI/LO, with valid/ready and flush.
// Optional MULDIV_EARLY_OUT_EN lets trivial divides (zero divisor or |a|<|b|) finish right after setup.
module integer_muldiv_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int MUL_LATENCY = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [2:0]            i_op,
  input  logic [DATA_WIDTH-1:0] i_op1,
  input  logic [DATA_WIDTH-1:0] i_op2,
  input  logic                  i_flush,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic [DATA_WIDTH-1:0] o_hi,
  output logic [DATA_WIDTH-1:0] o_lo,
  output logic                  o_div_zero
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);
  localparam int LW = MUL_LATENCY > 1 ? MUL_LATENCY - 1 : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);
  typedef enum logic [2:0] {IDLE, MUL, DIV_SETUP, DIV_ITER, DIV_FIX, DONE} state_t;
  state_t state_q, state_d;
  logic [2:0]   op_q, op_d, src_op;
  logic [W-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d, res_q, res_d;
  logic [W-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [W-1:0] mul_a, mul_b, mag_a, mag_b, quo_fix, rem_fix;
  logic [2*W-1:0] prod;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] sr_q, sr_d;
  logic neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d, dz_q, dz_d, div_zero_q, div_zero_d;
  logic accept, mul_s, div_s, dz_now, early, fin;

  // One restoring step: shift the next dividend bit into the remainder and try to subtract.
  function automatic logic [2*W-1:0] div_step(input logic [W-1:0] r, input logic [W-1:0] q,
                                              input logic [W-1:0] d);
    logic [W+1:0] t;
    t = {1'b0, r, q[W-1]} - {2'b0, d};
    return t[W+1] ? {r[W-2:0], q[W-1], q[W-2:0], 1'b0} : {t[W-1:0], q[W-2:0], 1'b1};
  endfunction

  assign accept  = i_valid && state_q == IDLE && !i_flush;
  assign src_op  = state_q == IDLE ? i_op : op_q;
  assign mul_a   = state_q == IDLE ? i_op1 : a_q;
  assign mul_b   = state_q == IDLE ? i_op2 : b_q;
  assign mul_s   = ~src_op[0];
  assign prod    = {{W{mul_s & mul_a[W-1]}}, mul_a} * {{W{mul_s & mul_b[W-1]}}, mul_b};
  assign div_s   = ~op_q[0];
  assign mag_a   = (div_s & a_q[W-1]) ? -a_q : a_q;
  assign mag_b   = (div_s & b_q[W-1]) ? -b_q : b_q;
  assign dz_now  = ~|b_q;
  assign quo_fix = neg_quo_q ? -quo_q : quo_q;
  assign rem_fix = neg_rem_q ? -rem_q : rem_q;
`ifdef MULDIV_EARLY_OUT_EN
  assign early = dz_now || mag_a < mag_b;
`else
  assign early = 1'b0;
`endif
  assign fin = state_d == DONE && state_q != DONE;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = !accept ? IDLE : i_op[2] ? DONE : i_op[1] ? DIV_SETUP :
                           (MUL_LATENCY == 1 ? DONE : MUL);
      MUL:       state_d = i_flush ? IDLE : sr_q[LW-1] ? DONE : MUL;
      DIV_SETUP: state_d = i_flush ? IDLE : early ? DONE : DIV_ITER;
      DIV_ITER:  state_d = i_flush ? IDLE : cnt_q == LAST ? DIV_FIX : DIV_ITER;
      DIV_FIX:   state_d = i_flush ? IDLE : DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    o_ready = state_q == IDLE;
    o_done  = state_q == DONE;
  end

  always_comb begin
    op_d = op_q;
    a_d = a_q;
    b_d = b_q;
    sr_d = sr_q;
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dz_d = dz_q;
    hi_d = hi_q;
    lo_d = lo_q;
    res_d = res_q;
    div_zero_d = div_zero_q;
    if (accept) begin
      op_d = i_op;
      a_d  = i_op1;
      b_d  = i_op2;
      sr_d = LW'(1);
    end
    if (state_q == MUL) sr_d = sr_q << 1;
    // Setup already performs the first quotient bit so the divide fits DATA_WIDTH+2 cycles.
    if (state_q == DIV_SETUP) begin
      {rem_d, quo_d} = div_step('0, mag_a, mag_b);
      dvs_d = mag_b;
      cnt_d = CW'(1);
      neg_quo_d = div_s & (a_q[W-1] ^ b_q[W-1]);
      neg_rem_d = div_s & a_q[W-1];
      dz_d = dz_now;
    end
    if (state_q == DIV_ITER) begin
      {rem_d, quo_d} = div_step(rem_q, quo_q, dvs_q);
      cnt_d = cnt_q + CW'(1);
    end
    if (fin) begin
      div_zero_d = 1'b0;
      if (src_op[2]) begin
        res_d = src_op[1] ? i_op1 : (src_op[0] ? lo_q : hi_q);
        hi_d  = src_op == 3'd6 ? i_op1 : hi_q;
        lo_d  = src_op == 3'd7 ? i_op1 : lo_q;
      end else if (!src_op[1]) begin
        {hi_d, lo_d} = prod;
        res_d = prod[W-1:0];
      end else if (state_q == DIV_SETUP) begin
        lo_d = dz_now ? '1 : '0;
        hi_d = a_q;
        res_d = dz_now ? '1 : '0;
        div_zero_d = dz_now;
      end else begin
        lo_d = dz_q ? '1 : quo_fix;
        hi_d = dz_q ? a_q : rem_fix;
        res_d = dz_q ? '1 : quo_fix;
        div_zero_d = dz_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      sr_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
      res_q <= '0;
      div_zero_q <= 1'b0;
    end else begin
      op_q <= op_d;
      a_q <= a_d;
      b_q <= b_d;
      sr_q <= sr_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dz_q <= dz_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      res_q <= res_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign o_result   = res_q;
  assign o_hi       = hi_q;
  assign o_lo       = lo_q;
  assign o_div_zero = div_zero_q;
endmodule

// File: tb/tb_integer_muldiv_unit.sv
// tb_integer_muldiv_unit: directed vectors with hand-computed results for integer_muldiv_unit.
module tb_integer_muldiv_unit;
  logic clk, rst, i_valid, o_ready, i_flush, o_done, o_div_zero;
  logic [2:0]  i_op;
  logic [31:0] i_op1, i_op2, o_result, o_hi, o_lo;
  int n_err = 0, n_chk = 0;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int EO_LAT = 2;
`else
  localparam int EO_LAT = 34;
`endif

  integer_muldiv_unit dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_op(i_op),
    .i_op1(i_op1), .i_op2(i_op2), .i_flush(i_flush), .o_done(o_done),
    .o_result(o_result), .o_hi(o_hi), .o_lo(o_lo), .o_div_zero(o_div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int lat, input logic [31:0] ehi, input logic [31:0] elo,
                       input logic [31:0] eres, input logic edz);
    int n;
    logic rdy_busy;
    @(negedge clk);
    chk({tag, ".ready"}, o_ready, 1);
    i_valid = 1'b1;
    i_op = op;
    i_op1 = a;
    i_op2 = b;
    @(negedge clk);
    i_valid = 1'b0;
    n = 1;
    rdy_busy = 1'b0;
    while (!o_done && n < 200) begin
      rdy_busy |= o_ready;
      @(negedge clk);
      n++;
    end
    chk({tag, ".lat"}, n, lat);
    chk({tag, ".busy_ready"}, rdy_busy | o_ready, 0);
    chk({tag, ".hi"}, o_hi, ehi);
    chk({tag, ".lo"}, o_lo, elo);
    chk({tag, ".result"}, o_result, eres);
    chk({tag, ".div_zero"}, o_div_zero, edz);
  endtask

  initial begin
    int dones;
    logic seen;
    rst = 1'b1;
    i_valid = 1'b0;
    i_flush = 1'b0;
    i_op = '0;
    i_op1 = '0;
    i_op2 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst.ready", o_ready, 1);
    chk("rst.done", o_done, 0);
    chk("rst.result", o_result, 0);
    chk("rst.hi", o_hi, 0);
    chk("rst.lo", o_lo, 0);
    chk("rst.div_zero", o_div_zero, 0);

    do_op("mult",   3'd0, 32'hFFFF_FFFE, 32'd3, 3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'hFFFF_FFFA, 0);
    do_op("multu",  3'd1, 32'hFFFF_FFFE, 32'd3, 3, 32'h0000_0002, 32'hFFFF_FFFA, 32'hFFFF_FFFA, 0);
    do_op("div",    3'd2, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 0);
    do_op("divu",   3'd3, 32'd100, 32'd7, 34, 32'd2, 32'd14, 32'd14, 0);
    do_op("divu_z", 3'd3, 32'd100, 32'd0, EO_LAT, 32'd100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    do_op("divu_s", 3'd3, 32'd5, 32'd9, EO_LAT, 32'd5, 32'd0, 32'd0, 0);
    do_op("div_ov", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'd0, 32'h8000_0000, 32'h8000_0000, 0);
    do_op("div_z",  3'd2, 32'hFFFF_FFF9, 32'd0, EO_LAT, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    do_op("mtlo",   3'd7, 32'h0000_ABCD, 32'd0, 1, 32'hFFFF_FFF9, 32'h0000_ABCD, 32'h0000_ABCD, 0);
    do_op("mthi",   3'd6, 32'h0000_1234, 32'd0, 1, 32'h0000_1234, 32'h0000_ABCD, 32'h0000_1234, 0);
    do_op("mflo",   3'd5, 32'd0, 32'd0, 1, 32'h0000_1234, 32'h0000_ABCD, 32'h0000_ABCD, 0);

    // Flush a divide in flight at T+10
    @(negedge clk);
    i_valid = 1'b1;
    i_op = 3'd3;
    i_op1 = 32'd50;
    i_op2 = 32'd3;
    @(negedge clk);
    i_valid = 1'b0;
    seen = 1'b0;
    for (int k = 1; k < 10; k++) begin
      seen |= o_done;
      @(negedge clk);
    end
    seen |= o_done;
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    chk("flush.ready", o_ready, 1);
    chk("flush.done", o_done, 0);
    chk("flush.hi", o_hi, 32'h1234);
    chk("flush.lo", o_lo, 32'hABCD);
    repeat (40) begin
      seen |= o_done;
      @(negedge clk);
    end
    chk("flush.no_done", seen, 0);
    do_op("mfhi", 3'd4, 32'd0, 32'd0, 1, 32'h0000_1234, 32'h0000_ABCD, 32'h0000_1234, 0);

    // Flush in the acceptance cycle drops an MT
    @(negedge clk);
    i_valid = 1'b1;
    i_op = 3'd6;
    i_op1 = 32'h5555;
    i_flush = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    i_flush = 1'b0;
    chk("acc_flush.ready", o_ready, 1);
    chk("acc_flush.done", o_done, 0);
    chk("acc_flush.hi", o_hi, 32'h1234);

    // Flush during DONE is ignored
    @(negedge clk);
    i_valid = 1'b1;
    i_op = 3'd7;
    i_op1 = 32'h7777;
    @(negedge clk);
    i_valid = 1'b0;
    chk("done_flush.done", o_done, 1);
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    chk("done_flush.ready", o_ready, 1);
    chk("done_flush.lo", o_lo, 32'h7777);
    chk("done_flush.result", o_result, 32'h7777);

    // i_valid while busy must not start another command
    @(negedge clk);
    i_valid = 1'b1;
    i_op = 3'd1;
    i_op1 = 32'd7;
    i_op2 = 32'd6;
    @(negedge clk);
    i_op = 3'd6;
    i_op1 = 32'hDEAD;
    dones = 0;
    for (int k = 1; k <= 8; k++) begin
      if (k == 3) i_valid = 1'b0;
      dones += int'(o_done);
      @(negedge clk);
    end
    chk("busy_valid.dones", dones, 1);
    chk("busy_valid.hi", o_hi, 0);
    chk("busy_valid.lo", o_lo, 42);

    // Reset at T+2 of a MULT
    @(negedge clk);
    i_valid = 1'b1;
    i_op = 3'd0;
    i_op1 = 32'd3;
    i_op2 = 32'd5;
    @(negedge clk);
    i_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst.hi", o_hi, 0);
    chk("mid_rst.lo", o_lo, 0);
    chk("mid_rst.ready", o_ready, 1);
    chk("mid_rst.done", o_done, 0);
    seen = 1'b0;
    repeat (5) begin
      seen |= o_done;
      @(negedge clk);
    end
    chk("mid_rst.no_done", seen, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
